mult_result_writer: RTL
=======================

# mult_result_writer

Downstream stage of the constant-multiply unit. Captures the 225-bit flattened 5×5 result matrix (nine bits per element: bit 8 = overflow flag, bits 7:0 = truncated product) on a start strobe. Streams the 25 elements out one per handshake over a byte-wide valid/ready port with element index. Accumulates a sticky overflow summary and a per-element overflow mask for the status register.

## Interface
Parameters:
- `DIM`, 5: matrix dimension; element count is DIM*DIM.
- `ELEM_W`, 9: bits per element; MSB is the overflow flag, the low ELEM_W-1 bits are data.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: capture `resultado` and begin streaming; honoured only in IDLE.
- `resultado`, input, DIM*DIM*ELEM_W: flattened matrix; element i occupies bits [i*ELEM_W +: ELEM_W], row-major.
- `out_ready`, input, 1: consumer accepts the current element.
- `out_valid`, output, 1: `out_data`/`out_ovf`/`out_idx` hold a valid element.
- `out_data`, output, ELEM_W-1: data bits of the current element.
- `out_ovf`, output, 1: overflow bit of the current element.
- `out_idx`, output, 5: index 0..DIM*DIM-1 of the current element.
- `busy`, output, 1: high in SEND and DONE.
- `done`, output, 1: one-cycle pulse after the last element transfers.
- `ovf_any`, output, 1: OR of all overflow bits of the captured matrix.
- `ovf_mask`, output, DIM*DIM: bit i = overflow bit of element i.

## Operation
- Reset: state IDLE. `out_valid`, `out_data`, `out_ovf`, `out_idx`, `busy`, `done`, `ovf_any`, and `ovf_mask` are all 0. The capture register is cleared.
- IDLE:
  - On `start`=1, register the full `resultado` into an internal capture register.
  - Set `ovf_mask` from the MSBs of all elements and `ovf_any` = |mask, both in the same edge.
  - Set the index to 0 and go to SEND.
- SEND:
  - `out_valid`=1; outputs present element `out_idx` from the capture register, never from live `resultado`.
  - A transfer occurs on a rising edge with `out_valid`&&`out_ready`.
  - On a transfer with idx < DIM*DIM-1: idx increments.
  - On a transfer with idx = DIM*DIM-1: go to DONE.
  - With `out_ready`=0, all outputs hold stable.
- DONE: `out_valid`=0, `done`=1 for exactly one cycle, then IDLE.
- `start` in SEND or DONE is ignored; the capture is not disturbed.
- `ovf_any`/`ovf_mask` hold after DONE until the next accepted `start`.
- `out_data`/`out_ovf`/`out_idx` in IDLE/DONE hold their last value; they are don't-care while `out_valid`=0, except after reset, when they are 0.
- `rst_n` low mid-stream: immediate return to IDLE with all reset values; the partial stream is abandoned and no `done` is issued.

## Timing
- Start-to-first-valid: `start` sampled at edge N; `out_valid`=1 from edge N.
- Throughput: one element per cycle when `out_ready` is held high. Full stream is 25 cycles of `out_valid`, then a `done` pulse at the 26th cycle after `start`.
- Back-to-back: the earliest next `start` is the cycle after `done` (IDLE). Minimum start-to-start period is 27 cycles.
- All outputs are registered; no combinational path from `out_ready` or `start` to any output.

## Structure
- Shared package/header: `MAT_DIM`=5, `ELEM_W`=9, `N_ELEM`=25, `IDX_W`=5, and state encodings IDLE/SEND/DONE. These are also used by the multiplier and loader stages.
- One FSM with capture register, index counter, and a 25:1 element mux.
- Natural sub-module: `elem_sel` (combinational element mux by index), reusable by the upstream loader's readback path.

## Test plan
- Reset and idle: hold `rst_n`=0, then release with no `start` → all outputs 0; `busy`=0 indefinitely.
- Full stream, always ready: element i = {0, 8'(i*3)}, `out_ready`=1 → 25 consecutive transfers with `out_data`=0,3,…,72 and `out_idx`=0..24. `done` pulses at cycle 26. `ovf_any`=0, `ovf_mask`=0.
- Overflow capture: elements 2 and 24 have bit 8 set → `ovf_mask`=25'h1000004 and `ovf_any`=1 from the start edge. `out_ovf`=1 only at idx 2 and 24.
- Backpressure: toggle `out_ready` 1,0,0,1,… → `out_data`/`out_idx` stable during stall cycles. Every element is delivered exactly once, in order. Change `resultado` mid-stream → output unaffected.
- Ignored start: pulse `start` at idx 10 with a different matrix → stream continues with the original data. `ovf_mask` is unchanged; exactly one `done`.
- Async reset mid-stream: assert `rst_n`=0 at idx 7 between edges → `out_valid`, `busy`, and `ovf_any` drop immediately with no `done`. A new `start` after release streams from idx 0.

Source files
------------

// File: rtl/mult_result_writer_pkg.sv
// Shared constants and state encoding for the constant-multiply pipeline
// (multiplier, loader and result-writer stages).
package mult_result_writer_pkg;

  localparam int MAT_DIM = 5;
  localparam int ELEM_W  = 9;
  localparam int N_ELEM  = MAT_DIM * MAT_DIM;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } wr_state_t;

  // Gathers the overflow flag (element MSB) of every element of a flattened matrix.
  function automatic logic [N_ELEM-1:0] ovf_bits(input logic [N_ELEM*ELEM_W-1:0] mat);
    logic [N_ELEM-1:0] bits;
    bits = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      bits[i] = mat[i*ELEM_W + ELEM_W - 1];
    end
    return bits;
  endfunction

endpackage

// File: rtl/mult_result_writer_if.sv
// Byte-wide element stream with index: producer drives valid/data/ovf/idx,
// consumer drives ready.
interface mult_result_writer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic [IDX_W-1:0]  out_idx;

  modport master (
    output out_valid,
    output out_data,
    output out_ovf,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ovf,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/mult_result_writer_elem_sel.sv
// Combinational element mux: picks element idx out of a flattened row-major
// matrix; an out-of-range index yields zero.
module mult_result_writer_elem_sel #(
  parameter int N      = 25,
  parameter int ELEM_W = 9,
  parameter int IDX_W  = 5
) (
  input  logic [N*ELEM_W-1:0] vec,
  input  logic [IDX_W-1:0]    idx,
  output logic [ELEM_W-1:0]   elem
);

  // Index-addressed slice with range guard
  always_comb begin
    elem = '0;
    if (int'(idx) < N) begin
      elem = vec[int'(idx)*ELEM_W +: ELEM_W];
    end else begin
      elem = '0;
    end
  end

endmodule

// File: rtl/mult_result_writer.sv
// Captures the result matrix on start and streams it element by element over a
// valid/ready port, keeping a sticky overflow mask for the status register.
module mult_result_writer #(
  parameter int DIM    = mult_result_writer_pkg::MAT_DIM,
  parameter int ELEM_W = mult_result_writer_pkg::ELEM_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIM*DIM*ELEM_W-1:0] resultado,
  mult_result_writer_if.master      bus,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf_any,
  output logic [DIM*DIM-1:0]        ovf_mask
);

  import mult_result_writer_pkg::*;

  localparam int N_EL = DIM * DIM;
  localparam int IW   = $clog2(N_EL);
  localparam int DW   = ELEM_W - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_EL - 1);

  wr_state_t               state_r, state_s;
  logic [N_EL*ELEM_W-1:0]  cap_r, cap_s;
  logic [IW-1:0]           idx_r, idx_s;
  logic                    valid_r, valid_s;
  logic [DW-1:0]           data_r, data_s;
  logic                    ovf_r, ovf_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    any_r, any_s;
  logic [N_EL-1:0]         mask_r, mask_s;
  logic [N_EL-1:0]         live_mask_s;

  logic [N_EL*ELEM_W-1:0]  sel_vec_s;
  logic [IW-1:0]           sel_idx_s;
  logic [ELEM_W-1:0]       sel_elem_s;

  // Element feeding the output registers: element 0 of the live matrix while
  // capturing, otherwise the successor of the current index in the capture.
  always_comb begin
    sel_vec_s = cap_r;
    sel_idx_s = idx_r + IW'(1);
    if (state_r == ST_IDLE) begin
      sel_vec_s = resultado;
      sel_idx_s = '0;
    end else begin
      sel_vec_s = cap_r;
      sel_idx_s = idx_r + IW'(1);
    end
  end

  mult_result_writer_elem_sel #(
    .N      (N_EL),
    .ELEM_W (ELEM_W),
    .IDX_W  (IW)
  ) u_elem_sel (
    .vec  (sel_vec_s),
    .idx  (sel_idx_s),
    .elem (sel_elem_s)
  );

  // Overflow flags of the live matrix, latched only when a start is accepted
  always_comb begin
    live_mask_s = '0;
    for (int i = 0; i < N_EL; i++) begin
      live_mask_s[i] = resultado[i*ELEM_W + ELEM_W - 1];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cap_s   = cap_r;
    idx_s   = idx_r;
    valid_s = valid_r;
    data_s  = data_r;
    ovf_s   = ovf_r;
    done_s  = 1'b0;
    any_s   = any_r;
    mask_s  = mask_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SEND;
          cap_s   = resultado;
          mask_s  = live_mask_s;
          any_s   = |live_mask_s;
          idx_s   = '0;
          valid_s = 1'b1;
          data_s  = sel_elem_s[DW-1:0];
          ovf_s   = sel_elem_s[ELEM_W-1];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (valid_r && bus.out_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
            valid_s = 1'b0;
            done_s  = 1'b1;
          end else begin
            idx_s  = idx_r + IW'(1);
            data_s = sel_elem_s[DW-1:0];
            ovf_s  = sel_elem_s[ELEM_W-1];
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cap_r   <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
      data_r  <= '0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      any_r   <= 1'b0;
      mask_r  <= '0;
    end else begin
      state_r <= state_s;
      cap_r   <= cap_s;
      idx_r   <= idx_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      ovf_r   <= ovf_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      any_r   <= any_s;
      mask_r  <= mask_s;
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.out_data  = data_r;
  assign bus.out_ovf   = ovf_r;
  assign bus.out_idx   = idx_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign ovf_any       = any_r;
  assign ovf_mask      = mask_r;

endmodule
